// File: rtl/alu_issue_ctrl.sv
// Execute-stage issuer: decodes a MIPS instruction into an ALU request and returns a registered
// writeback/branch response. Define ALU_ISSUE_BRANCH_TARGET_EN to compute rsp_target.
module alu_issue_ctrl #(
    parameter logic [31:0] RESET_PC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instr,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_rs_val,
    input  logic [31:0] req_rt_val,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [5:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_wb_en,
    output logic [4:0]  rsp_wb_reg,
    output logic        rsp_taken,
    output logic [31:0] rsp_target,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state_q, state_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs_f, rt_f, rd_f, shamt;
    logic [15:0] imm;
    logic signed [31:0] imm_sext;

    assign op       = req_instr[31:26];
    assign rs_f     = req_instr[25:21];
    assign rt_f     = req_instr[20:16];
    assign rd_f     = req_instr[15:11];
    assign shamt    = req_instr[10:6];
    assign funct    = req_instr[5:0];
    assign imm      = req_instr[15:0];
    assign imm_sext = {{16{imm[15]}}, imm};

    logic        dec_legal, dec_wb_en, dec_branch, dec_jr;
    logic [5:0]  dec_ctrl;
    logic [31:0] dec_in1, dec_in2;
    logic [4:0]  dec_wb_reg;

    always_comb begin
        dec_legal  = 1'b1;
        dec_ctrl   = 6'd0;
        dec_in1    = req_rs_val;
        dec_in2    = req_rt_val;
        dec_wb_en  = 1'b0;
        dec_wb_reg = rt_f;
        dec_branch = 1'b0;
        dec_jr     = 1'b0;
        case (op)
            6'h00: begin
                dec_ctrl   = funct;
                dec_wb_en  = 1'b1;
                dec_wb_reg = rd_f;
                case (funct)
                    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                    6'b100101, 6'b100110, 6'b101010, 6'b101011: ;
                    6'b000000, 6'b000010, 6'b000011: begin
                        dec_in1 = req_rt_val;
                        dec_in2 = {27'd0, shamt};
                    end
                    6'b000100, 6'b000110: begin
                        dec_in1 = req_rt_val;
                        dec_in2 = {27'd0, req_rs_val[4:0]};
                    end
                    6'b001000: begin
                        dec_wb_en = 1'b0;
                        dec_jr    = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
                case (op)
                    6'h09:   dec_ctrl = 6'b100001;
                    6'h0A:   dec_ctrl = 6'b101010;
                    6'h0B:   dec_ctrl = 6'b101011;
                    default: dec_ctrl = 6'b100000;
                endcase
                dec_in2   = $unsigned(imm_sext);
                dec_wb_en = (op != 6'h2B);
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_ctrl  = (op == 6'h0C) ? 6'b100100 :
                            (op == 6'h0D) ? 6'b100101 : 6'b100110;
                dec_in2   = {16'd0, imm};
                dec_wb_en = 1'b1;
            end
            6'h0F: begin
                dec_ctrl  = 6'b111000;
                dec_in2   = {imm, 16'd0};
                dec_wb_en = 1'b1;
            end
            6'h04, 6'h05: begin
                dec_ctrl   = (op == 6'h04) ? 6'b110000 : 6'b110001;
                dec_branch = 1'b1;
            end
            6'h06, 6'h07: begin
                dec_ctrl   = (op == 6'h07) ? 6'b110010 : 6'b110011;
                dec_in2    = 32'd0;
                dec_branch = 1'b1;
            end
            6'h01: begin
                dec_in2    = 32'd0;
                dec_branch = 1'b1;
                if (rt_f == 5'd1)      dec_ctrl = 6'b110100;
                else if (rt_f == 5'd0) dec_ctrl = 6'b110101;
                else                   dec_legal = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase
        // $zero is never a writeback destination
        if (dec_wb_reg == 5'd0) dec_wb_en = 1'b0;
        if (!dec_legal) begin
            dec_ctrl   = 6'd0;
            dec_in1    = 32'd0;
            dec_in2    = 32'd0;
            dec_wb_en  = 1'b0;
            dec_wb_reg = 5'd0;
            dec_branch = 1'b0;
            dec_jr     = 1'b0;
        end
    end

    logic [31:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
    logic [5:0]  alu_ctrl_q, alu_ctrl_d;
    logic        wb_en_q, wb_en_d, branch_q, branch_d, jr_q, jr_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_wb_en_q, rsp_wb_en_d;
    logic        rsp_taken_q, rsp_taken_d, rsp_illegal_q, rsp_illegal_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [4:0]  rsp_wb_reg_q, rsp_wb_reg_d;

    always_comb begin
        state_d       = state_q;
        alu_in1_d     = alu_in1_q;
        alu_in2_d     = alu_in2_q;
        alu_ctrl_d    = alu_ctrl_q;
        wb_en_d       = wb_en_q;
        wb_reg_d      = wb_reg_q;
        branch_d      = branch_q;
        jr_d          = jr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_wb_en_d   = rsp_wb_en_q;
        rsp_wb_reg_d  = rsp_wb_reg_q;
        rsp_taken_d   = rsp_taken_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec_legal) begin
                        state_d    = EXEC;
                        alu_in1_d  = dec_in1;
                        alu_in2_d  = dec_in2;
                        alu_ctrl_d = dec_ctrl;
                        wb_en_d    = dec_wb_en;
                        wb_reg_d   = dec_wb_reg;
                        branch_d   = dec_branch;
                        jr_d       = dec_jr;
                    end else begin
                        // Illegal encodings skip the ALU and answer immediately
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_out;
                rsp_wb_en_d  = wb_en_q;
                rsp_wb_reg_d = wb_reg_q;
                rsp_taken_d  = branch_q ? alu_zero : jr_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    alu_in1_d     = 32'd0;
                    alu_in2_d     = 32'd0;
                    alu_ctrl_d    = 6'd0;
                    wb_en_d       = 1'b0;
                    wb_reg_d      = 5'd0;
                    branch_d      = 1'b0;
                    jr_d          = 1'b0;
                    rsp_valid_d   = 1'b0;
                    rsp_result_d  = 32'd0;
                    rsp_wb_en_d   = 1'b0;
                    rsp_wb_reg_d  = 5'd0;
                    rsp_taken_d   = 1'b0;
                    rsp_illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            alu_in1_q     <= 32'd0;
            alu_in2_q     <= 32'd0;
            alu_ctrl_q    <= 6'd0;
            wb_en_q       <= 1'b0;
            wb_reg_q      <= 5'd0;
            branch_q      <= 1'b0;
            jr_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 32'd0;
            rsp_wb_en_q   <= 1'b0;
            rsp_wb_reg_q  <= 5'd0;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_in1_q     <= alu_in1_d;
            alu_in2_q     <= alu_in2_d;
            alu_ctrl_q    <= alu_ctrl_d;
            wb_en_q       <= wb_en_d;
            wb_reg_q      <= wb_reg_d;
            branch_q      <= branch_d;
            jr_q          <= jr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_wb_en_q   <= rsp_wb_en_d;
            rsp_wb_reg_q  <= rsp_wb_reg_d;
            rsp_taken_q   <= rsp_taken_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

`ifdef ALU_ISSUE_BRANCH_TARGET_EN
    logic [31:0] dec_target, target_q, target_d, rsp_target_q, rsp_target_d;

    assign dec_target = dec_jr ? req_rs_val
                               : req_pc + RESET_PC_OFFSET + ($unsigned(imm_sext) << 2);

    always_comb begin
        target_d     = target_q;
        rsp_target_d = rsp_target_q;
        case (state_q)
            IDLE:    if (req_valid && dec_legal) target_d = (dec_branch || dec_jr) ? dec_target : 32'd0;
            EXEC:    rsp_target_d = target_q;
            RESP:    if (rsp_ready) begin
                         target_d     = 32'd0;
                         rsp_target_d = 32'd0;
                     end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target_q     <= 32'd0;
            rsp_target_q <= 32'd0;
        end else begin
            target_q     <= target_d;
            rsp_target_q <= rsp_target_d;
        end
    end

    assign rsp_target = rsp_target_q;
`else
    logic unused_pc;
    assign unused_pc  = ^req_pc;
    assign rsp_target = 32'd0;
`endif

    assign req_ready   = (state_q == IDLE);
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_wb_en   = rsp_wb_en_q;
    assign rsp_wb_reg  = rsp_wb_reg_q;
    assign rsp_taken   = rsp_taken_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: decode, response latency, backpressure, illegal and reset abort.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = 32'd0, req_pc = 32'd0, req_rs_val = 32'd0, req_rt_val = 32'd0;
    logic [31:0] alu_in1, alu_in2;
    logic [5:0]  alu_ctrl;
    logic [31:0] alu_out = 32'd0;
    logic        alu_zero = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_wb_en;
    logic [4:0]  rsp_wb_reg;
    logic        rsp_taken;
    logic [31:0] rsp_target;
    logic        rsp_illegal;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr), .req_pc(req_pc),
        .req_rs_val(req_rs_val), .req_rt_val(req_rt_val),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_wb_en(rsp_wb_en), .rsp_wb_reg(rsp_wb_reg), .rsp_taken(rsp_taken),
        .rsp_target(rsp_target), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    // Present one request for a single edge, then drop req_valid
    task automatic accept(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] rs, input logic [31:0] rt);
        req_instr  = ins;
        req_pc     = pc;
        req_rs_val = rs;
        req_rt_val = rt;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    logic [31:0] exp_tgt;

    initial begin
        step();
        step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_result", rsp_result, 0);
        reset = 1'b0;
        step();

        // ADD rs=5 rt=7 rd=3
        accept(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h0, 32'd5, 32'd7);
        chk("add_ctrl", alu_ctrl, 32'h20);
        chk("add_in1", alu_in1, 5);
        chk("add_in2", alu_in2, 7);
        chk("add_exec_rsp_valid", rsp_valid, 0);
        alu_out = 32'd12;
        step();
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_result", rsp_result, 12);
        chk("add_wb_en", rsp_wb_en, 1);
        chk("add_wb_reg", rsp_wb_reg, 3);
        chk("add_taken", rsp_taken, 0);
        chk("add_illegal", rsp_illegal, 0);

        // Backpressure: response held, pending ADDI waits
        alu_out    = 32'hDEAD;
        req_instr  = itype(6'h08, 5'd3, 5'd4, 16'hFFFF);
        req_rs_val = 32'd10;
        req_rt_val = 32'd0;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 12);
            chk("bp_wb_reg", rsp_wb_reg, 3);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_alu_ctrl", alu_ctrl, 32'h20);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_rsp_valid", rsp_valid, 0);
        chk("hs_req_ready", req_ready, 1);
        chk("hs_alu_in1", alu_in1, 0);
        step();
        req_valid = 1'b0;
        chk("addi_ctrl", alu_ctrl, 32'h20);
        chk("addi_in1", alu_in1, 10);
        chk("addi_in2", alu_in2, 32'hFFFF_FFFF);
        alu_out = 32'd9;
        step();
        chk("addi_result", rsp_result, 9);
        chk("addi_wb_reg", rsp_wb_reg, 4);
        chk("addi_wb_en", rsp_wb_en, 1);
        release_rsp();

        // ORI and LUI immediates
        accept(itype(6'h0D, 5'd1, 5'd2, 16'h8000), 32'h0, 32'd1, 32'd0);
        chk("ori_ctrl", alu_ctrl, 6'b100101);
        chk("ori_in2", alu_in2, 32'h0000_8000);
        step();
        release_rsp();
        accept(itype(6'h0F, 5'd0, 5'd2, 16'h1234), 32'h0, 32'd0, 32'd0);
        chk("lui_ctrl", alu_ctrl, 6'b111000);
        chk("lui_in2", alu_in2, 32'h1234_0000);
        step();
        release_rsp();

`ifdef ALU_ISSUE_BRANCH_TARGET_EN
        exp_tgt = 32'h110;
`else
        exp_tgt = 32'h0;
`endif
        // BEQ taken and not taken
        accept(itype(6'h04, 5'd1, 5'd2, 16'd3), 32'h100, 32'd8, 32'd8);
        chk("beq_ctrl", alu_ctrl, 6'b110000);
        chk("beq_in2", alu_in2, 8);
        alu_zero = 1'b1;
        step();
        chk("beq_taken", rsp_taken, 1);
        chk("beq_target", rsp_target, exp_tgt);
        chk("beq_wb_en", rsp_wb_en, 0);
        release_rsp();
        accept(itype(6'h04, 5'd1, 5'd2, 16'd3), 32'h100, 32'd8, 32'd9);
        alu_zero = 1'b0;
        step();
        chk("beq_nt_taken", rsp_taken, 0);
        chk("beq_nt_valid", rsp_valid, 1);
        release_rsp();

        // SLL shamt=4 rt=1
        accept(rtype(5'd0, 5'd2, 5'd5, 5'd4, 6'b000000), 32'h0, 32'h55, 32'd1);
        chk("sll_ctrl", alu_ctrl, 0);
        chk("sll_in1", alu_in1, 1);
        chk("sll_in2", alu_in2, 4);
        step();
        release_rsp();

        // JR
`ifdef ALU_ISSUE_BRANCH_TARGET_EN
        exp_tgt = 32'h400;
`else
        exp_tgt = 32'h0;
`endif
        accept(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000), 32'h200, 32'h400, 32'd0);
        chk("jr_ctrl", alu_ctrl, 6'b001000);
        step();
        chk("jr_taken", rsp_taken, 1);
        chk("jr_wb_en", rsp_wb_en, 0);
        chk("jr_target", rsp_target, exp_tgt);
        release_rsp();

        // SW and ADD to $zero never write back
        accept(itype(6'h2B, 5'd1, 5'd6, 16'h0010), 32'h0, 32'd0, 32'd0);
        step();
        chk("sw_wb_en", rsp_wb_en, 0);
        release_rsp();
        accept(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'b100000), 32'h0, 32'd1, 32'd1);
        step();
        chk("rd0_wb_en", rsp_wb_en, 0);
        release_rsp();

        // BLTZ
        accept(itype(6'h01, 5'd1, 5'd0, 16'd2), 32'h0, 32'hFFFF_FFFF, 32'd77);
        chk("bltz_ctrl", alu_ctrl, 6'b110101);
        chk("bltz_in2", alu_in2, 0);
        step();
        release_rsp();

        // Illegal opcode answers one cycle after accept
        accept(itype(6'h3F, 5'd1, 5'd2, 16'h1), 32'h0, 32'd3, 32'd4);
        chk("ill_valid", rsp_valid, 1);
        chk("ill_flag", rsp_illegal, 1);
        chk("ill_result", rsp_result, 0);
        chk("ill_alu_ctrl", alu_ctrl, 0);
        chk("ill_wb_en", rsp_wb_en, 0);
        release_rsp();
        chk("ill_clear", rsp_illegal, 0);

        // Reset while in EXEC aborts the instruction
        accept(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h0, 32'd5, 32'd7);
        chk("abort_exec_ctrl", alu_ctrl, 32'h20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_alu_ctrl", alu_ctrl, 0);
        step();
        chk("abort_rsp_valid2", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
